// File: rtl/axil_reg_master_if.sv
// AXI4-Lite bus bundle used between axil_reg_master and a register slave.
// Ports (modport master): AW/W/AR address, payload and VALID out, READY in;
// B/R response and VALID in, READY out. Modport slave is the mirror image.
interface axil_reg_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator: runs one register write or read per command and
// returns the data/response on a valid/ready response port.
// Ports: ACLK, ARESET (async, active high); cmd_* command port (valid/ready);
// rsp_* response port (valid/ready); txn_count (wrapping), err_count
// (saturating); m_axi AXI4-Lite master bus. All outputs are registered.
// Optional macro AXIL_REG_MASTER_VERIFY_EN: every OKAY write is followed by a
// read-back of the same address, compared on the strobed bytes; adds the
// verify_err output.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WRITE   | AWVALID/WVALID out, each drops after its own handshake
// WRESP   | BREADY high, waiting for BVALID
// RADDR   | ARVALID high, waiting for ARREADY (also the read-back leg)
// RDATA   | RREADY high, waiting for RVALID
// RSP     | rsp_valid high, waiting for rsp_ready
module axil_reg_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0]  C_M_AXI_PROT       = 3'b000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [15:0]                     txn_count,
  output logic [7:0]                      err_count,
`ifdef AXIL_REG_MASTER_VERIFY_EN
  output logic                            verify_err,
`endif
  axil_reg_master_if.master               m_axi
);
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RSP   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [15:0]     txn_count_q, txn_count_d;
  logic [7:0]      err_count_q, err_count_d;

  function automatic logic [7:0] err_bump(input logic [7:0] cnt, input logic hit);
    return (hit && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  endfunction

`ifdef AXIL_REG_MASTER_VERIFY_EN
  logic          verify_q, verify_d;
  logic          verify_err_q, verify_err_d;
  logic          verify_miss;
  logic [DW-1:0] strb_mask;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < int'(DW / 8); b++) strb_mask[8*b +: 8] = {8{wstrb_q[b]}};
  end
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    txn_count_d = txn_count_q;
    err_count_d = err_count_q;
`ifdef AXIL_REG_MASTER_VERIFY_EN
    verify_d     = verify_q;
    verify_err_d = verify_err_q;
    verify_miss  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // AW and W complete independently; leave once both VALIDs are down.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (m_axi.bvalid && bready_q) begin
          bready_d = 1'b0;
`ifdef AXIL_REG_MASTER_VERIFY_EN
          if (m_axi.bresp == 2'b00) begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
            verify_d  = 1'b1;
          end else begin
`endif
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = m_axi.bresp;
            txn_count_d = txn_count_q + 16'd1;
            err_count_d = err_bump(err_count_q, m_axi.bresp != 2'b00);
`ifdef AXIL_REG_MASTER_VERIFY_EN
          end
`endif
        end
      end
      S_RADDR: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi.rvalid && rready_q) begin
          rready_d    = 1'b0;
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          txn_count_d = txn_count_q + 16'd1;
`ifdef AXIL_REG_MASTER_VERIFY_EN
          verify_miss  = verify_q && (((m_axi.rdata ^ wdata_q) & strb_mask) != '0);
          verify_err_d = verify_miss;
          verify_d     = 1'b0;
          err_count_d  = err_bump(err_count_q, (m_axi.rresp != 2'b00) || verify_miss);
`else
          err_count_d = err_bump(err_count_q, m_axi.rresp != 2'b00);
`endif
        end
      end
      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
`ifdef AXIL_REG_MASTER_VERIFY_EN
          verify_err_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      txn_count_q <= 16'd0;
      err_count_q <= 8'd0;
`ifdef AXIL_REG_MASTER_VERIFY_EN
      verify_q     <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      txn_count_q <= txn_count_d;
      err_count_q <= err_count_d;
`ifdef AXIL_REG_MASTER_VERIFY_EN
      verify_q     <= verify_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign txn_count = txn_count_q;
  assign err_count = err_count_q;
`ifdef AXIL_REG_MASTER_VERIFY_EN
  assign verify_err = verify_err_q;
`endif

  // One latched address serves both the write and the (read-back) read leg.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = C_M_AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = C_M_AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axil_reg_master.sv
// Testbench for axil_reg_master: randomized commands against a slave model
// with programmable per-channel delays; expected responses come from an
// address-rule reference model and are checked by a scoreboard monitor.
// Slave address rule: addr[7:6] = 2'b10 -> SLVERR, writes ignored, reads
// return 0x0BAD0BAD; 2'b11 -> OKAY but read data has bits [1:0] flipped;
// otherwise plain memory indexed by addr[5:2].
module tb_axil_reg_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
`ifdef AXIL_REG_MASTER_VERIFY_EN
  logic        verify_err;
  localparam int WR_EXTRA = 2;
`else
  localparam int WR_EXTRA = 0;
`endif

  axil_reg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();

  axil_reg_master dut (
    .ACLK(clk), .ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .txn_count(txn_count), .err_count(err_count),
`ifdef AXIL_REG_MASTER_VERIFY_EN
    .verify_err(verify_err),
`endif
    .m_axi(m)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] txn;
    logic [7:0]  err;
    logic        verr;
  } exp_t;

  exp_t sb[$];
  int pending = 0;
  int rsp_cyc = 0;

  // Reference model state
  logic [31:0] mmem [16];
  logic [15:0] m_txn = 16'd0;
  logic [7:0]  m_err = 8'd0;
  // Slave memory
  logic [31:0] smem [16];

  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0, cfg_hold = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;

  task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output exp_t e);
    logic [1:0] rg;
    int idx;
    rg  = addr[7:6];
    idx = int'(addr[5:2]);
    e.verr = 1'b0;
    e.rdata = 32'd0;
    e.resp = 2'b00;
    if (wr) begin
      if (rg == 2'b10) begin
        e.resp = 2'b10;
      end else begin
        for (int b = 0; b < 4; b++) if (strb[b]) mmem[idx][8*b +: 8] = data[8*b +: 8];
`ifdef AXIL_REG_MASTER_VERIFY_EN
        e.rdata = mmem[idx] ^ ((rg == 2'b11) ? 32'h3 : 32'h0);
        e.verr  = (rg == 2'b11) && strb[0];
`endif
      end
    end else begin
      if (rg == 2'b10) begin
        e.rdata = 32'h0BAD0BAD;
        e.resp  = 2'b10;
      end else begin
        e.rdata = mmem[idx] ^ ((rg == 2'b11) ? 32'h3 : 32'h0);
      end
    end
    m_txn = m_txn + 16'd1;
    if ((e.resp != 2'b00 || e.verr) && m_err != 8'hFF) m_err = m_err + 8'd1;
    e.txn = m_txn;
    e.err = m_err;
  endtask

  // AXI4-Lite slave: decisions made at negedge, handshake happens at next posedge
  bit aw_seen, aw_have, w_seen, w_have, b_pend, ar_seen, r_pend;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [31:0] s_awaddr;

  initial begin
    m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 0;
    m.arready = 0; m.rvalid = 0; m.rresp = 0; m.rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_seen = 0; aw_have = 0; w_seen = 0; w_have = 0; b_pend = 0; ar_seen = 0; r_pend = 0;
        m.awready = 0; m.wready = 0; m.bvalid = 0; m.arready = 0; m.rvalid = 0;
      end else begin
        m.bvalid = 0;
        if (b_pend) begin if (b_wait == 0) m.bvalid = 1; else b_wait--; end
        if (m.bvalid && m.bready) begin
          b_pend = 0; aw_have = 0; w_have = 0; aw_seen = 0; w_seen = 0;
        end
        m.awready = 0;
        if (m.awvalid && !aw_have) begin
          if (!aw_seen) begin aw_seen = 1; aw_wait = cfg_aw; end
          if (aw_wait == 0) m.awready = 1; else aw_wait--;
        end
        if (m.awvalid && m.awready) begin
          aw_have = 1; s_awaddr = m.awaddr;
          check("awaddr", m.awaddr, cur_addr);
          check("awprot", m.awprot, 3'b000);
        end
        m.wready = 0;
        if (m.wvalid && !w_have) begin
          if (!w_seen) begin w_seen = 1; w_wait = cfg_w; end
          if (w_wait == 0) m.wready = 1; else w_wait--;
        end
        if (m.wvalid && m.wready) begin
          w_have = 1;
          check("wdata", m.wdata, cur_wdata);
          check("wstrb", m.wstrb, cur_wstrb);
          if (s_awaddr[7:6] != 2'b10 || !aw_have) begin end
        end
        if (aw_have && w_have && !b_pend) begin
          if (s_awaddr[7:6] != 2'b10)
            for (int b = 0; b < 4; b++) if (cur_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = cur_wdata[8*b +: 8];
          m.bresp = (s_awaddr[7:6] == 2'b10) ? 2'b10 : 2'b00;
          b_wait = cfg_b;
          b_pend = 1;
        end
        m.rvalid = 0;
        if (r_pend) begin if (r_wait == 0) m.rvalid = 1; else r_wait--; end
        if (m.rvalid && m.rready) begin r_pend = 0; ar_seen = 0; end
        m.arready = 0;
        if (m.arvalid && !r_pend) begin
          if (!ar_seen) begin ar_seen = 1; ar_wait = cfg_ar; end
          if (ar_wait == 0) m.arready = 1; else ar_wait--;
        end
        if (m.arvalid && m.arready) begin
          check("araddr", m.araddr, cur_addr);
          check("arprot", m.arprot, 3'b000);
          if (m.araddr[7:6] == 2'b10) begin
            m.rdata = 32'h0BAD0BAD; m.rresp = 2'b10;
          end else begin
            m.rdata = smem[m.araddr[5:2]] ^ ((m.araddr[7:6] == 2'b11) ? 32'h3 : 32'h0);
            m.rresp = 2'b00;
          end
          r_wait = cfg_r;
          r_pend = 1;
        end
      end
    end
  end

  // Protocol monitor: VALID held with stable payload, BREADY only after AW and W
  initial begin
    bit p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    p_aw = 0; p_w = 0; p_ar = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw) begin check("awvalid_held", m.awvalid, 1); check("awaddr_stable", m.awaddr, p_awaddr); end
        if (p_w) begin check("wvalid_held", m.wvalid, 1); check("wdata_stable", {m.wstrb, m.wdata}, {p_wstrb, p_wdata}); end
        if (p_ar) begin check("arvalid_held", m.arvalid, 1); check("araddr_stable", m.araddr, p_araddr); end
        if (m.bready) check("bready_after_aw_w", m.awvalid | m.wvalid, 0);
        p_aw = m.awvalid && !m.awready; p_awaddr = m.awaddr;
        p_w  = m.wvalid && !m.wready;   p_wdata = m.wdata; p_wstrb = m.wstrb;
        p_ar = m.arvalid && !m.arready; p_araddr = m.araddr;
      end
    end
  end

  // Scoreboard monitor and response consumer
  initial begin
    bit in_rsp;
    int hold;
    exp_t e;
    logic [31:0] h_rdata;
    logic [1:0]  h_resp;
    in_rsp = 0; hold = 0;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 0; rsp_ready = 0;
      end else if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1; rsp_cyc = cyc; hold = cfg_hold;
          if (sb.size() == 0) begin
            check("unexpected_rsp", rsp_valid, 0);
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
            check("txn_count", txn_count, e.txn);
            check("err_count", err_count, e.err);
`ifdef AXIL_REG_MASTER_VERIFY_EN
            check("verify_err", verify_err, e.verr);
`endif
          end
          h_rdata = rsp_rdata; h_resp = rsp_resp;
        end else begin
          check("rsp_stable", {rsp_resp, rsp_rdata}, {h_resp, h_rdata});
        end
        if (hold > 0) begin rsp_ready = 0; hold--; end
        else rsp_ready = 1;
        if (rsp_ready) begin in_rsp = 0; pending--; end
      end else begin
        rsp_ready = 0;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (pending != 0 && t < 500) begin @(negedge clk); t++; end
    if (pending != 0) begin
      check("rsp_timeout", pending, 0);
      finish_now();
    end
    @(negedge clk);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output int hs_cyc);
    exp_t e;
    int t;
    logic [31:0] r;
    cur_addr = addr; cur_wdata = data; cur_wstrb = strb;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", cmd_ready, 1);
      finish_now();
    end
    hs_cyc = cyc;
    model(wr, addr, data, strb, e);
    sb.push_back(e);
    pending++;
    @(negedge clk);
    cmd_valid = 0;
    r = $urandom(); cmd_addr = r; cmd_wdata = ~r; cmd_wstrb = r[3:0]; cmd_write = r[4];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    logic [31:0] r, a;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    cur_addr = 0; cur_wdata = 0; cur_wstrb = 0;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 32'h5A5A0000 + i * 32'h01010101;
      smem[i] = mmem[i];
    end
    mmem[1] = 32'hABCD0001; smem[1] = 32'hABCD0001;

    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awvalid", m.awvalid, 0);
    check("rst_wvalid", m.wvalid, 0);
    check("rst_bready", m.bready, 0);
    check("rst_arvalid", m.arvalid, 0);
    check("rst_rready", m.rready, 0);
    check("rst_awaddr", m.awaddr, 0);
    check("rst_araddr", m.araddr, 0);
    check("rst_wdata", m.wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_err_count", err_count, 0);
    rst = 0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Always-ready write
    issue(1, 32'h0, 32'h0101FFFF, 4'hF, n);
    check("aw_w_valid_n1", {m.awvalid, m.wvalid}, 2'b11);
    wait_idle();
    check("write_latency", rsp_cyc - n, 3 + WR_EXTRA);

    // Read with RVALID delayed 5 cycles
    cfg_r = 5;
    issue(0, 32'h4, 32'h0, 4'h0, n);
    wait_idle();
    check("read_latency", rsp_cyc - n, 8);
    cfg_r = 0;

    // W completes 3 cycles before AW
    cfg_aw = 3;
    issue(1, 32'h8, 32'h12345678, 4'hF, n);
    @(negedge clk);
    check("w_dropped_aw_held", {m.wvalid, m.awvalid, m.bready}, 3'b010);
    wait_idle();
    check("split_latency", rsp_cyc - n, 6 + WR_EXTRA);
    cfg_aw = 0;

    // SLVERR with rsp_ready held low 4 cycles
    cfg_hold = 4;
    issue(1, 32'h80, 32'hCAFEF00D, 4'hF, n);
    wait_idle();
    cfg_hold = 0;

`ifdef AXIL_REG_MASTER_VERIFY_EN
    issue(1, 32'h10, 32'hDEAD0011, 4'h3, n);
    wait_idle();
    issue(1, 32'hC0, 32'hDEAD0011, 4'h3, n);
    wait_idle();
`endif

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      a = $urandom();
      cfg_aw = $urandom_range(0, 3); cfg_w = $urandom_range(0, 3); cfg_b = $urandom_range(0, 3);
      cfg_ar = $urandom_range(0, 3); cfg_r = $urandom_range(0, 5); cfg_hold = $urandom_range(0, 3);
      issue(r[0], {a[31:8], r[2:1], a[5:0]}, $urandom(), r[7:4], n);
      wait_idle();
    end
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_hold = 0;

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      issue(1, 32'h84, 32'h0, 4'hF, n);
      wait_idle();
    end
    check("err_saturated", err_count, 8'hFF);

    // Reset while waiting for read data
    cfg_r = 30;
    issue(0, 32'h14, 32'h0, 4'h0, n);
    t = 0;
    while (!m.rready && t < 20) begin @(negedge clk); t++; end
    check("reached_rdata", m.rready, 1);
    #2 rst = 1;
    #1;
    check("rst_async_rready", m.rready, 0);
    check("rst_async_valids", {m.arvalid, m.awvalid, m.wvalid, rsp_valid, cmd_ready}, 5'b0);
    repeat (2) @(negedge clk);
    sb.delete();
    pending = 0;
    m_txn = 0; m_err = 0;
    cfg_r = 0;
    rst = 0;
    @(negedge clk);
    check("cmd_ready_after_midrst", cmd_ready, 1);
    repeat (8) @(negedge clk);
    check("no_rsp_after_midrst", rsp_valid, 0);
    check("txn_after_midrst", txn_count, 0);
    issue(0, 32'h4, 32'h0, 4'h0, n);
    wait_idle();

    finish_now();
  end
endmodule
